// File: rtl/rx_channel.sv
// ---------------------------------------------------------------------------
// rx_channel
//
// Receiving end of a single AXI-style VALID/READY channel. Beats accepted
// from the bus are stored in a small first-word-fall-through buffer and are
// presented to a local consumer through its own valid/ready handshake.
// READY is a registered signal, and it drops on the same edge at which the
// buffer becomes full, so the buffer can never overflow. A sticky monitor
// flags transmitters that break the VALID/READY hold rules.
//
// Ports
//   ACLK       in   1      channel clock, all logic on the rising edge
//   ARESETn    in   1      synchronous, active-low reset
//   VALID      in   1      bus VALID from the transmitter
//   READY      out  1      bus READY to the transmitter (registered)
//   xDATA      in   WIDTH  bus data, sampled when VALID && READY
//   rx_data    out  WIDTH  head-of-buffer data (FWFT)
//   rx_valid   out  1      buffer non-empty, rx_data is valid
//   rx_ready   in   1      consumer takes the head beat this cycle
//   rx_count   out  CW     current occupancy, 0..DEPTH
//   proto_err  out  1      sticky transmitter-protocol violation flag
// ---------------------------------------------------------------------------
module rx_channel #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             VALID,
    output logic             READY,
    input  logic [WIDTH-1:0] xDATA,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CW-1:0]    rx_count,
    output logic             proto_err
);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ready_q;
    logic             ready_d;

    // Protocol monitor history: what the bus looked like one cycle ago.
    logic             prev_valid_q;
    logic             prev_ready_q;
    logic [WIDTH-1:0] prev_data_q;
    logic             mon_en_q;
    logic             proto_err_q;
    logic             proto_err_d;

    logic             push_s;
    logic             pop_s;
    logic             valid_s;
    logic             viol_a_s;
    logic             viol_b_s;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // The buffer is non-empty whenever the registered occupancy is non-zero.
    assign valid_s = (count_q != '0);

    // A push is only possible while the registered READY is high, so a full
    // buffer never takes a beat. There is no bypass path, so a pop can only
    // take data that was stored on an earlier edge.
    assign push_s  = VALID && ready_q;
    assign pop_s   = valid_s && rx_ready;

    // Next-state for pointers, occupancy and READY.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            2'b11:   count_d = count_q;
            2'b00:   count_d = count_q;
            default: count_d = count_q;
        endcase

        // READY looks at the post-update occupancy: it falls on the edge
        // that fills the buffer and rises on the edge after a pop from full.
        ready_d = (count_d < CNT_MAX);
    end

    // Buffer pointers, occupancy and the registered READY.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Buffer storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge ACLK) begin
        if (ARESETn && push_s) begin
            mem_q[wr_ptr_q] <= xDATA;
        end
    end

    // ------------------------------------------------------------------
    // Protocol monitor
    // ------------------------------------------------------------------
    // Once VALID has been raised without a handshake, the transmitter must
    // keep VALID high (A) and keep the data stable (B) until READY takes it.
    assign viol_a_s = prev_valid_q && !prev_ready_q && !VALID;
    assign viol_b_s = prev_valid_q && !prev_ready_q && VALID &&
                      (xDATA != prev_data_q);

    // Sticky error: once set it can only be cleared by reset. The monitor
    // only observes; it never blocks a beat.
    always_comb begin
        proto_err_d = proto_err_q;
        if (mon_en_q && (viol_a_s || viol_b_s)) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_q;
        end
    end

    // Monitor history and enable; the enable stays low for the first cycle
    // after reset release so that history from before reset is never used.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
            prev_data_q  <= '0;
            mon_en_q     <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            prev_valid_q <= VALID;
            prev_ready_q <= ready_q;
            prev_data_q  <= xDATA;
            mon_en_q     <= 1'b1;
            proto_err_q  <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign READY     = ready_q;
    assign rx_valid  = valid_s;
    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_count  = count_q;
    assign proto_err = proto_err_q;

endmodule
